// File: rtl/mor1kx_ibus_wb_bridge_espresso_pkg.sv
// Shared encodings for the espresso ibus-to-Wishbone bridge: FSM states and
// the fixed Wishbone B3 classic-cycle qualifiers it drives.
package mor1kx_ibus_wb_bridge_espresso_pkg;

    typedef enum logic [1:0] {
        IBUS_IDLE  = 2'd0,
        IBUS_READ  = 2'd1,
        IBUS_DRAIN = 2'd2
    } ibus_state_e;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [3:0] WB_SEL_WORD    = 4'hf;

endpackage

// File: rtl/mor1kx_ibus_hit_buffer.sv
// Single-entry instruction hit buffer: remembers the last word fetched over
// Wishbone together with its address so an identical re-fetch skips the bus.
module mor1kx_ibus_hit_buffer
#(
    parameter int    DW                 = 32,
    parameter string FEATURE_HIT_BUFFER = "ENABLED"
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_i,
    input  logic [DW-1:0] fill_adr_i,
    input  logic [DW-1:0] fill_dat_i,
    input  logic          invalidate_i,
    input  logic [DW-1:0] lookup_adr_i,
    output logic          hit_o,
    output logic [DW-1:0] dat_o
);

    localparam bit HIT_EN = (FEATURE_HIT_BUFFER != "NONE");

    logic          valid_q;
    logic [DW-1:0] tag_q;
    logic [DW-1:0] data_q;

    // An invalidate in the same cycle as a fill wins and leaves the entry empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (invalidate_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_adr_i;
            data_q  <= fill_dat_i;
        end
    end

    assign hit_o = HIT_EN && valid_q && (tag_q == lookup_adr_i);
    assign dat_o = data_q;

endmodule

// File: rtl/mor1kx_ibus_wb_bridge_espresso.sv
// Espresso instruction-bus bridge: converts fetch requests into Wishbone B3
// classic reads, serving repeated fetches of the same PC from a hit buffer.
module mor1kx_ibus_wb_bridge_espresso
    import mor1kx_ibus_wb_bridge_espresso_pkg::*;
#(
    parameter int    OPTION_OPERAND_WIDTH = 32,
    parameter string FEATURE_HIT_BUFFER   = "ENABLED"
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_i,
    input  logic                            ibus_req_i,
    input  logic                            ibus_burst_i,
    output logic                            ibus_ack_o,
    output logic                            ibus_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_o,
    input  logic                            buf_invalidate_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    input  logic                            wbm_rty_i
);

    localparam int W = OPTION_OPERAND_WIDTH;

    ibus_state_e state_q;
    logic        cyc_q;
    logic        hit_ack_q;
    logic [W-1:0] adr_q;
    logic [W-1:0] dat_q;

    logic         buf_hit;
    logic [W-1:0] buf_dat;
    logic         match;
    logic         on_bus;
    logic         bus_term;
    logic         fwd_ack;
    logic         fwd_err;
    logic         bus_fill;
    logic         bus_err;
    logic         unused_burst;

    assign unused_burst = ibus_burst_i;

    assign match    = ibus_req_i && (ibus_adr_i == adr_q);
    assign on_bus   = (state_q != IBUS_IDLE);
    assign bus_term = wbm_ack_i || wbm_err_i || wbm_rty_i;
    assign fwd_ack  = (state_q == IBUS_READ) && wbm_ack_i && match;
    assign fwd_err  = (state_q == IBUS_READ) && wbm_err_i && !wbm_ack_i && match;
    assign bus_fill = on_bus && wbm_ack_i;
    assign bus_err  = on_bus && wbm_err_i && !wbm_ack_i;

    mor1kx_ibus_hit_buffer #(
        .DW                 (W),
        .FEATURE_HIT_BUFFER (FEATURE_HIT_BUFFER)
    ) u_hit_buffer (
        .clk          (clk),
        .rst          (rst),
        .fill_i       (bus_fill),
        .fill_adr_i   (adr_q),
        .fill_dat_i   (wbm_dat_i),
        .invalidate_i (buf_invalidate_i || bus_err),
        .lookup_adr_i (ibus_adr_i),
        .hit_o        (buf_hit),
        .dat_o        (buf_dat)
    );

    // A retargeted fetch moves READ to DRAIN; the cycle still runs to its
    // termination because Wishbone cycles are never cut short here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IBUS_IDLE;
            cyc_q     <= 1'b0;
            hit_ack_q <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            hit_ack_q <= 1'b0;
            case (state_q)
                IBUS_IDLE: begin
                    if (ibus_req_i) begin
                        if (buf_hit) begin
                            hit_ack_q <= 1'b1;
                            dat_q     <= buf_dat;
                        end else begin
                            adr_q   <= ibus_adr_i;
                            cyc_q   <= 1'b1;
                            state_q <= IBUS_READ;
                        end
                    end
                end
                IBUS_READ: begin
                    if (bus_term) begin
                        cyc_q   <= 1'b0;
                        state_q <= IBUS_IDLE;
                        if (fwd_ack)
                            dat_q <= wbm_dat_i;
                    end else if (!match) begin
                        state_q <= IBUS_DRAIN;
                    end
                end
                IBUS_DRAIN: begin
                    if (bus_term) begin
                        cyc_q   <= 1'b0;
                        state_q <= IBUS_IDLE;
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    state_q <= IBUS_IDLE;
                end
            endcase
        end
    end

    assign ibus_ack_o = hit_ack_q || fwd_ack;
    assign ibus_err_o = fwd_err;
    assign ibus_dat_o = fwd_ack ? wbm_dat_i : dat_q;

    assign wbm_adr_o = adr_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = WB_SEL_WORD;
    assign wbm_cti_o = WB_CTI_CLASSIC;
    assign wbm_bte_o = WB_BTE_LINEAR;

endmodule

// File: tb/tb_mor1kx_ibus_wb_bridge_espresso.sv
// Directed scenarios plus random fetch/slave traffic against a transaction-level
// model of the bridge (one outstanding bus read, one buffered word).
module tb_mor1kx_ibus_wb_bridge_espresso;

    logic        clk;
    logic        rst;
    logic [31:0] ibus_adr_i;
    logic        ibus_req_i;
    logic        ibus_burst_i;
    logic        ibus_ack_o;
    logic        ibus_err_o;
    logic [31:0] ibus_dat_o;
    logic        buf_invalidate_i;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    int total = 0;
    int bad   = 0;
    int ackSeen   = 0;
    int cycStarts = 0;
    bit prevCyc   = 1'b0;

    // Model: an outstanding read (and whether fetch has walked away from it),
    // a promised buffer-served ack, and the buffered word itself.
    bit          mBusy, mAbandon, mHitAck, mValid;
    logic [31:0] mBusAdr, mHitDat, mTag, mData;

    bit          cRst, cReq, cInv, cAck, cErr, cRty;
    logic [31:0] cAdr, cDat;
    bit          lastResp;

    bit          fReq;
    logic [31:0] fAdr;

    mor1kx_ibus_wb_bridge_espresso dut (
        .clk              (clk),
        .rst              (rst),
        .ibus_adr_i       (ibus_adr_i),
        .ibus_req_i       (ibus_req_i),
        .ibus_burst_i     (ibus_burst_i),
        .ibus_ack_o       (ibus_ack_o),
        .ibus_err_o       (ibus_err_o),
        .ibus_dat_o       (ibus_dat_o),
        .buf_invalidate_i (buf_invalidate_i),
        .wbm_adr_o        (wbm_adr_o),
        .wbm_cyc_o        (wbm_cyc_o),
        .wbm_stb_o        (wbm_stb_o),
        .wbm_we_o         (wbm_we_o),
        .wbm_sel_o        (wbm_sel_o),
        .wbm_cti_o        (wbm_cti_o),
        .wbm_bte_o        (wbm_bte_o),
        .wbm_dat_i        (wbm_dat_i),
        .wbm_ack_i        (wbm_ack_i),
        .wbm_err_i        (wbm_err_i),
        .wbm_rty_i        (wbm_rty_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    function automatic logic [31:0] pickAdr();
        return 32'h100 + 32'(4 * $urandom_range(0, 5));
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input bit eCyc, input bit eAck, input bit eErr,
                               input logic [31:0] eDat, input logic [31:0] eAdr);
        checkVal("cyc", {31'd0, wbm_cyc_o}, {31'd0, eCyc});
        checkVal("stb", {31'd0, wbm_stb_o}, {31'd0, eCyc});
        checkVal("ack", {31'd0, ibus_ack_o}, {31'd0, eAck});
        checkVal("err", {31'd0, ibus_err_o}, {31'd0, eErr});
        if (eAck)
            checkVal("dat", ibus_dat_o, eDat);
        if (eCyc)
            checkVal("adr", wbm_adr_o, eAdr);
    endtask

    task automatic modelReset();
        mBusy    = 1'b0;
        mAbandon = 1'b0;
        mHitAck  = 1'b0;
        mValid   = 1'b0;
        mBusAdr  = '0;
        mHitDat  = '0;
        mTag     = '0;
        mData    = '0;
    endtask

    // Drive one cycle's inputs and compare the outputs the model predicts for it.
    task automatic applyStimulus(input bit r, input bit q, input logic [31:0] a, input bit inv,
                                 input bit sa, input bit se, input bit sr, input logic [31:0] sd);
        bit          match, eAck, eErr;
        logic [31:0] eDat;
        rst = r; ibus_req_i = q; ibus_adr_i = a; buf_invalidate_i = inv;
        wbm_ack_i = sa; wbm_err_i = se; wbm_rty_i = sr; wbm_dat_i = sd;
        cRst = r; cReq = q; cAdr = a; cInv = inv; cAck = sa; cErr = se; cRty = sr; cDat = sd;
        #1;
        match = q && (a == mBusAdr);
        eAck  = mHitAck || (mBusy && !mAbandon && match && sa);
        eErr  = mBusy && !mAbandon && match && se && !sa;
        eDat  = mHitAck ? mHitDat : sd;
        checkOutput(mBusy, eAck, eErr, eDat, mBusAdr);
        if (ibus_ack_o === 1'b1) ackSeen++;
        if (wbm_cyc_o === 1'b1 && !prevCyc) cycStarts++;
        prevCyc  = (wbm_cyc_o === 1'b1);
        lastResp = eAck || eErr;
    endtask

    task automatic advance();
        bit match;
        match = cReq && (cAdr == mBusAdr);
        if (cRst) begin
            modelReset();
        end else begin
            mHitAck = 1'b0;
            if (mBusy) begin
                if (cAck || cErr || cRty) begin
                    mBusy = 1'b0;
                    if (cAck) begin
                        mValid = 1'b1;
                        mTag   = mBusAdr;
                        mData  = cDat;
                    end else if (cErr) begin
                        mValid = 1'b0;
                    end
                end else if (!match) begin
                    mAbandon = 1'b1;
                end
            end else if (cReq) begin
                if (mValid && mTag == cAdr) begin
                    mHitAck = 1'b1;
                    mHitDat = mData;
                end else begin
                    mBusy    = 1'b1;
                    mBusAdr  = cAdr;
                    mAbandon = 1'b0;
                end
            end
            if (cInv) mValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit q, input logic [31:0] a);
        applyStimulus(1'b0, q, a, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        advance();
    endtask

    initial begin
        rst = 1'b1; ibus_req_i = 1'b0; ibus_adr_i = '0; ibus_burst_i = 1'b0;
        buf_invalidate_i = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        fReq = 1'b0; fAdr = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        modelReset();
        $display("[TB] reset state");
        checkVal("rst cyc", {31'd0, wbm_cyc_o}, 32'd0);
        checkVal("rst ack", {31'd0, ibus_ack_o}, 32'd0);
        checkVal("rst err", {31'd0, ibus_err_o}, 32'd0);
        checkVal("rst dat", ibus_dat_o, 32'd0);
        checkVal("rst adr", wbm_adr_o, 32'd0);
        checkVal("we", {31'd0, wbm_we_o}, 32'd0);
        checkVal("sel", {28'd0, wbm_sel_o}, 32'hf);
        checkVal("cti", {29'd0, wbm_cti_o}, 32'd0);
        checkVal("bte", {30'd0, wbm_bte_o}, 32'd0);

        $display("[TB] miss then hit on 0x100");
        step(1'b1, 32'h100);
        applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 0);
        checkVal("t1 stb at N+1", {31'd0, wbm_stb_o}, 32'd1);
        advance();
        step(1'b1, 32'h100);
        applyStimulus(0, 1, 32'h100, 0, 1, 0, 0, 32'h1500_0000);
        checkVal("t1 ack at N+3", {31'd0, ibus_ack_o}, 32'd1);
        checkVal("t1 dat", ibus_dat_o, 32'h1500_0000);
        advance();
        applyStimulus(0, 0, 32'h100, 0, 0, 0, 0, 0);
        checkVal("t1 cyc low at N+4", {31'd0, wbm_cyc_o}, 32'd0);
        advance();
        step(1'b1, 32'h100);
        applyStimulus(0, 0, 32'h100, 0, 0, 0, 0, 0);
        checkVal("t2 hit ack", {31'd0, ibus_ack_o}, 32'd1);
        checkVal("t2 hit dat", ibus_dat_o, 32'h1500_0000);
        checkVal("t2 no cyc", {31'd0, wbm_cyc_o}, 32'd0);
        advance();

        $display("[TB] retarget 0x104 -> 0x200");
        step(1'b1, 32'h104);
        step(1'b1, 32'h104);
        step(1'b1, 32'h200);
        applyStimulus(0, 1, 32'h200, 0, 0, 0, 0, 0);
        checkVal("t3 drain adr", wbm_adr_o, 32'h104);
        advance();
        applyStimulus(0, 1, 32'h200, 0, 1, 0, 0, 32'hDEAD_0104);
        checkVal("t3 drained ack hidden", {31'd0, ibus_ack_o}, 32'd0);
        advance();
        step(1'b1, 32'h104);
        applyStimulus(0, 1, 32'h200, 0, 0, 0, 0, 0);
        checkVal("t3 tag 0x104 hit", {31'd0, ibus_ack_o}, 32'd1);
        checkVal("t3 tag 0x104 dat", ibus_dat_o, 32'hDEAD_0104);
        advance();
        applyStimulus(0, 1, 32'h200, 0, 0, 0, 0, 0);
        checkVal("t3 0x200 issued", wbm_adr_o, 32'h200);
        advance();
        applyStimulus(0, 1, 32'h200, 0, 1, 0, 0, 32'h0200_0200);
        advance();
        step(1'b0, 32'h200);

        $display("[TB] bus error on 0x300");
        step(1'b1, 32'h300);
        step(1'b1, 32'h300);
        applyStimulus(0, 1, 32'h300, 0, 0, 1, 0, 0);
        checkVal("t4 err pulse", {31'd0, ibus_err_o}, 32'd1);
        checkVal("t4 no ack", {31'd0, ibus_ack_o}, 32'd0);
        advance();
        step(1'b1, 32'h200);
        applyStimulus(0, 1, 32'h200, 0, 0, 0, 0, 0);
        checkVal("t4 buffer invalid", {31'd0, wbm_cyc_o}, 32'd1);
        advance();
        applyStimulus(0, 1, 32'h200, 0, 1, 0, 0, 32'h0200_0200);
        advance();
        step(1'b1, 32'h300);
        applyStimulus(0, 1, 32'h300, 0, 0, 0, 0, 0);
        checkVal("t4 reissue adr", wbm_adr_o, 32'h300);
        advance();
        applyStimulus(0, 1, 32'h300, 0, 1, 0, 0, 32'h3000_3000);
        advance();
        step(1'b0, 32'h300);

        $display("[TB] retry on 0x400");
        ackSeen = 0;
        cycStarts = 0;
        step(1'b1, 32'h400);
        applyStimulus(0, 1, 32'h400, 0, 0, 0, 1, 0);
        advance();
        step(1'b1, 32'h400);
        step(1'b1, 32'h400);
        applyStimulus(0, 1, 32'h400, 0, 1, 0, 0, 32'h4000_4000);
        advance();
        step(1'b0, 32'h400);
        checkVal("t5 one ibus ack", ackSeen, 32'd1);
        checkVal("t5 two wb cycles", cycStarts, 32'd2);

        $display("[TB] invalidate in fill cycle, reset mid-read");
        step(1'b1, 32'h100);
        step(1'b1, 32'h100);
        applyStimulus(0, 1, 32'h100, 1, 1, 0, 0, 32'h1500_0000);
        advance();
        step(1'b0, 32'h100);
        step(1'b1, 32'h100);
        applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 0);
        checkVal("t6 miss after inval", {31'd0, wbm_cyc_o}, 32'd1);
        advance();
        applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, 0);
        advance();
        applyStimulus(0, 0, 32'h100, 0, 0, 0, 0, 0);
        checkVal("t6 cyc after rst", {31'd0, wbm_cyc_o}, 32'd0);
        checkVal("t6 ack after rst", {31'd0, ibus_ack_o}, 32'd0);
        advance();

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            bit          r, inv, sa, se, sr;
            logic [31:0] sd;
            int          k;
            r   = ($urandom_range(0, 499) == 0);
            inv = ($urandom_range(0, 19) == 0);
            sa = 1'b0; se = 1'b0; sr = 1'b0;
            sd = $urandom;
            if (mBusy && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 99);
                if (k < 75) begin
                    sa = 1'b1;
                    sd = memWord(mBusAdr);
                end else if (k < 88) begin
                    se = 1'b1;
                end else begin
                    sr = 1'b1;
                end
            end
            if (fReq && $urandom_range(0, 9) == 0) fAdr = pickAdr();
            applyStimulus(r, fReq, fAdr, inv, sa, se, sr, sd);
            advance();
            if (lastResp || !fReq) begin
                fReq = ($urandom_range(0, 3) != 0);
                fAdr = pickAdr();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
